mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master, one-slave arbiter for the pipeconnect memory bus. It shares the external memory port between the instruction-cache fill engine (master 0) and the data-side memory stage (master 1). Granted bursts stay locked to their owner up to a configurable length, and returning read data is routed back to the master that issued the read. It sits between stage_I / the D-side and the SRAM/SDRAM controller.

## Interface
Parameters:
- RD_LAT, 1: fixed slave read latency in cycles, from accepted read to valid RD.
- MAX_BURST, 8: maximum consecutive accepted beats one master may hold the grant while the other master is requesting.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m0_req  in  `REQ  I-side request bundle (A 32, R, W, WD 32, WBE 4).
- m0_res  out  `RES  I-side response bundle (HOLD, RD 32).
- m1_req  in  `REQ  D-side request bundle.
- m1_res  out  `RES  D-side response bundle.
- s_req  out  `REQ  request to memory slave.
- s_res  in  `RES  response from memory slave.

## Operation
- Active master: R|W asserted. A beat is accepted when the granted master is active and s_res`HOLD=0.
- Registered state: lock_valid, lock_id, beat_cnt (width clog2(MAX_BURST)+1), last_winner, rd_pipe[RD_LAT] of {valid, id}.
- Grant (combinational, same cycle):
  - Keep lock_id if lock_valid, the lock owner is still active, and the burst is not yet expired. Expired means beat_cnt==MAX_BURST and the other master is active.
  - Otherwise pick among the active masters by the priority rule (see Configuration).
  - If neither master is active: no grant.
- s_req = granted master's request. With no grant, s_req is all zeros.
- HOLD handling:
  - Granted master's HOLD = s_res`HOLD.
  - Non-granted active master's HOLD = 1.
  - Inactive master's HOLD = 0.
- Lock update:
  - On an accepted beat: lock_valid=1, lock_id=grant, last_winner=grant.
  - beat_cnt increments on an accepted beat if the grant is unchanged. It restarts at 1 on an accepted beat for a new owner.
  - If the owner drops R|W, lock_valid=0 and beat_cnt=0.
- Read return:
  - An accepted read pushes {1, grant} into rd_pipe. Anything else pushes {0, x}.
  - At the pipe output, the master whose id matches and whose valid bit is set receives RD = s_res`RD. The other master receives RD = 0.
  - This permits grant switches while reads are in flight.
- Writes produce no return entry.

## Timing
- Request path adds zero cycles: s_req is a combinational mux of the master requests.
- Read data reaches the owner's RD exactly RD_LAT cycles after the acceptance edge.
- Reset values (rst_n low, asynchronous):
  - lock_valid=0, beat_cnt=0, last_winner=1, all rd_pipe valid=0.
  - s_req`R=s_req`W=0, gated combinationally while rst_n is low.
  - m0/m1 HOLD=0, RD=0.
- Reset mid-burst: in-flight reads are discarded; their RD is never delivered. The first arbitration after release follows the reset last_winner.
- Simultaneous first requests from both masters: resolved by the priority rule.
- Burst expiry: when beat MAX_BURST of a locked owner is accepted and the other master is active, the grant moves to the other master on the next cycle. If the other master is idle, the owner keeps the grant and beat_cnt saturates at MAX_BURST.
- HOLD held high by the slave does not advance beat_cnt; the grant stays put.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: unlocked ties go to the master that is not last_winner.
- MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, with master 1 (D-side) always winning unlocked ties. Burst locking and MAX_BURST expiry still apply in both modes.

## Test plan
- Single master: m0 issues 8 reads at A=0x100..0x11C with HOLD=0 and RD_LAT=1.
  - Expect s_req`A to follow each address in the same cycle.
  - Expect m0 RD to carry each datum one cycle later, m1 RD=0, and m1 HOLD=0 throughout.
- Simultaneous first request, default build: m0 read and m1 write (A=0x200, WBE=0xF) in the same cycle.
  - Expect m1 granted with m0 HOLD=1.
  - Expect m0 to be accepted the cycle after m1 drops W.
- Same scenario with MEM_ARB_ROUND_ROBIN_EN defined, after reset:
  - Expect m0 to win first (last_winner=1).
  - On the next tie, expect m1 to win.
- Burst expiry with MAX_BURST=4: m0 streams 10 reads while m1 requests continuously.
  - Expect exactly 4 m0 beats, then m1 granted, then m0 resumes.
  - Expect every RD delivered to the correct master with no loss across the switch.
- Slave stall and mid-burst reset:
  - With s_res`HOLD=1 for 3 cycles during an m0 burst, expect beat_cnt unchanged and m0 HOLD=1.
  - Asserting rst_n=0 with a read in flight: expect s_req R/W=0 immediately, and no RD delivered to either master afterwards.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// pipeconnect memory bus bundle: request (A, R, W, WD, WBE) and response (HOLD, RD).
// The master modport drives the request; the slave modport answers it.
interface mem_arbiter_if;
    logic [31:0] a;
    logic        r;
    logic        w;
    logic [31:0] wd;
    logic [3:0]  wbe;
    logic        hold;
    logic [31:0] rd;

    modport master (output a, r, w, wd, wbe, input hold, rd);
    modport slave  (input a, r, w, wd, wbe, output hold, rd);
endinterface

// File: rtl/mem_arbiter.sv
// Two-master burst-locking arbiter for the pipeconnect memory bus, with read-return routing.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise master 1 wins unlocked ties.
module mem_arbiter #(
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 8
) (
    input  logic          clock,
    input  logic          rst_n,
    mem_arbiter_if.slave  m0_bus,
    mem_arbiter_if.slave  m1_bus,
    mem_arbiter_if.master s_bus
);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    logic             lock_valid_q, lock_valid_d;
    logic             lock_id_q, lock_id_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             last_winner_q, last_winner_d;
    logic [RD_LAT-1:0] rd_vld_q, rd_vld_d;
    logic [RD_LAT-1:0] rd_id_q, rd_id_d;

    logic act0, act1, owner_act, other_act, expired, keep;
    logic tie_id, gnt_vld, gnt_id, accept;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            lock_valid_q  <= 1'b0;
            lock_id_q     <= 1'b0;
            beat_cnt_q    <= '0;
            last_winner_q <= 1'b1;
            rd_vld_q      <= '0;
            rd_id_q       <= '0;
        end else begin
            lock_valid_q  <= lock_valid_d;
            lock_id_q     <= lock_id_d;
            beat_cnt_q    <= beat_cnt_d;
            last_winner_q <= last_winner_d;
            rd_vld_q      <= rd_vld_d;
            rd_id_q       <= rd_id_d;
        end
    end

    // Grant is combinational so the request path adds no cycles.
    always_comb begin
        act0      = m0_bus.r | m0_bus.w;
        act1      = m1_bus.r | m1_bus.w;
        owner_act = lock_id_q ? act1 : act0;
        other_act = lock_id_q ? act0 : act1;
        expired   = (beat_cnt_q == CNT_MAX) && other_act;
        keep      = lock_valid_q && owner_act && !expired;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        tie_id    = ~last_winner_q;
`else
        tie_id    = 1'b1;
`endif
        gnt_vld   = rst_n && (act0 || act1);
        if (keep)              gnt_id = lock_id_q;
        else if (act0 && act1) gnt_id = tie_id;
        else                   gnt_id = act1;
        accept    = gnt_vld && !s_bus.hold;
    end

    always_comb begin
        lock_valid_d  = lock_valid_q;
        lock_id_d     = lock_id_q;
        beat_cnt_d    = beat_cnt_q;
        last_winner_d = last_winner_q;
        if (accept) begin
            lock_valid_d  = 1'b1;
            lock_id_d     = gnt_id;
            last_winner_d = gnt_id;
            if (lock_valid_q && (lock_id_q == gnt_id))
                beat_cnt_d = (beat_cnt_q == CNT_MAX) ? beat_cnt_q : beat_cnt_q + CNT_W'(1);
            else
                beat_cnt_d = CNT_W'(1);
        end else if (lock_valid_q && !owner_act) begin
            lock_valid_d = 1'b0;
            beat_cnt_d   = '0;
        end
        rd_vld_d    = '0;
        rd_id_d     = '0;
        rd_vld_d[0] = accept && s_bus.r;
        rd_id_d[0]  = gnt_id;
        for (int i = 1; i < RD_LAT; i++) begin
            rd_vld_d[i] = rd_vld_q[i-1];
            rd_id_d[i]  = rd_id_q[i-1];
        end
    end

    always_comb begin
        s_bus.a   = '0;
        s_bus.r   = 1'b0;
        s_bus.w   = 1'b0;
        s_bus.wd  = '0;
        s_bus.wbe = '0;
        if (gnt_vld) begin
            s_bus.a   = gnt_id ? m1_bus.a   : m0_bus.a;
            s_bus.r   = gnt_id ? m1_bus.r   : m0_bus.r;
            s_bus.w   = gnt_id ? m1_bus.w   : m0_bus.w;
            s_bus.wd  = gnt_id ? m1_bus.wd  : m0_bus.wd;
            s_bus.wbe = gnt_id ? m1_bus.wbe : m0_bus.wbe;
        end
        m0_bus.hold = gnt_vld && act0 && (gnt_id ? 1'b1 : s_bus.hold);
        m1_bus.hold = gnt_vld && act1 && (gnt_id ? s_bus.hold : 1'b1);
        // Read data follows the id captured at acceptance, not the current grant.
        m0_bus.rd = (rd_vld_q[RD_LAT-1] && !rd_id_q[RD_LAT-1]) ? s_bus.rd : '0;
        m1_bus.rd = (rd_vld_q[RD_LAT-1] &&  rd_id_q[RD_LAT-1]) ? s_bus.rd : '0;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a transaction-level arbitration model
// queues expected bus/hold/read-return values, and a negedge monitor pops and compares them.
module tb_mem_arbiter;
    localparam int RD_LAT    = 1;
    localparam int MAX_BURST = 4;
    localparam int N_CYC     = 710;
    localparam int M_TIE = 0, M_SINGLE = 1, M_EXP = 2, M_STALL = 3, M_RAND = 4, M_IDLE = 5;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    mem_arbiter_if m0_if ();
    mem_arbiter_if m1_if ();
    mem_arbiter_if s_if ();

    mem_arbiter #(.RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .m0_bus(m0_if),
        .m1_bus(m1_if),
        .s_bus (s_if)
    );

    typedef struct {
        bit          in_rst;
        bit          h0, h1, r, w;
        logic [31:0] a, wd;
        logic [3:0]  wbe;
    } exp_cyc_t;
    typedef struct { int due; int id; logic [31:0] data; } exp_rd_t;
    typedef struct { int due; logic [31:0] a; } slv_t;

    exp_cyc_t exp_q[$];
    exp_rd_t  rd_q[$];
    slv_t     slv_q[$];

    int checks = 0, failures = 0, cyc = 0;
    bit done = 1'b0;

    // master-side transaction state
    bit          mact[2], mr[2], mw[2], macc[2];
    logic [31:0] ma[2], mwd[2];
    logic [3:0]  mwbe[2];
    int          n[2];
    int          n_single = 0, tie_rounds = 0;
    bit          tie_go;

    // reference arbitration state
    int own = -1, beats = 0, last = 1;

    function automatic logic [31:0] hsh(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:2], 2'b01};
    endfunction

    function automatic int mode_of(input int c);
        if (c <= 12)  return M_TIE;
        if (c <= 30)  return M_SINGLE;
        if (c <= 75)  return M_EXP;
        if (c <= 100) return M_STALL;
        if (c <= 700) return M_RAND;
        return M_IDLE;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, req);
        end
    endtask

    task automatic new_txn(input int i, input int md);
        mact[i] = 0; mr[i] = 0; mw[i] = 0; ma[i] = '0; mwd[i] = '0; mwbe[i] = '0;
        case (md)
            M_TIE: if (tie_go) begin
                mact[i] = 1;
                if (i == 0) begin
                    mr[i] = 1; ma[i] = 32'h300 + 32'(4 * n[i]);
                end else begin
                    mw[i] = 1; ma[i] = 32'h200; mwbe[i] = 4'hF; mwd[i] = $urandom;
                end
            end
            M_SINGLE: if (i == 0 && n_single < 8) begin
                mact[i] = 1; mr[i] = 1; ma[i] = 32'h100 + 32'(4 * n_single);
                n_single++;
            end
            M_EXP, M_STALL: if (i == 0 || md == M_EXP || cyc >= 86) begin
                mact[i] = 1;
                if (i == 0 || $urandom_range(0, 1) == 1) mr[i] = 1; else mw[i] = 1;
                ma[i] = (i == 1 ? 32'h800 : 32'h400) + 32'(4 * n[i]);
                mwd[i] = $urandom; mwbe[i] = 4'($urandom);
            end
            M_RAND: if ($urandom_range(0, 3) != 0) begin
                mact[i] = 1;
                if ($urandom_range(0, 1) == 1) mr[i] = 1; else mw[i] = 1;
                ma[i] = (i == 1 ? 32'hA000 : 32'h5000) + 32'(4 * $urandom_range(0, 255));
                mwd[i] = $urandom; mwbe[i] = 4'($urandom);
            end
            default: ;
        endcase
        n[i]++;
    endtask

    // slave: returns hsh(addr) RD_LAT cycles after each accepted read, noise otherwise
    always @(negedge clock)
        if (rst_n && s_if.r && !s_if.hold) slv_q.push_back('{cyc + RD_LAT, s_if.a});

    always @(negedge clock) begin
        if (!done && exp_q.size() > 0) begin
            exp_cyc_t e;
            e = exp_q.pop_front();
            chk("m0_hold", 32'(m0_if.hold), 32'(e.h0));
            chk("m1_hold", 32'(m1_if.hold), 32'(e.h1));
            chk("s_r", 32'(s_if.r), 32'(e.r));
            chk("s_w", 32'(s_if.w), 32'(e.w));
            if (!e.in_rst) begin
                chk("s_a", s_if.a, e.a);
                chk("s_wd", s_if.wd, e.wd);
                chk("s_wbe", 32'(s_if.wbe), 32'(e.wbe));
            end
            if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
                exp_rd_t x;
                x = rd_q.pop_front();
                chk("m0_rd", m0_if.rd, x.id == 0 ? x.data : 32'h0);
                chk("m1_rd", m1_if.rd, x.id == 1 ? x.data : 32'h0);
            end else begin
                chk("m0_rd_idle", m0_if.rd, 32'h0);
                chk("m1_rd_idle", m1_if.rd, 32'h0);
            end
        end
    end

    initial begin
        bit rdy[2];
        bit mid_done;
        int mid_rel, g, md;
        bit acc, hold;
        exp_cyc_t e;
        slv_t sv;
        mid_done = 0; mid_rel = -1;
        for (int i = 0; i < 2; i++) begin
            mact[i] = 0; mr[i] = 0; mw[i] = 0; macc[i] = 0; ma[i] = '0; mwd[i] = '0; mwbe[i] = '0; n[i] = 0;
        end
        m0_if.a = '0; m0_if.r = 0; m0_if.w = 0; m0_if.wd = '0; m0_if.wbe = '0;
        m1_if.a = '0; m1_if.r = 0; m1_if.w = 0; m1_if.wd = '0; m1_if.wbe = '0;
        s_if.hold = 0; s_if.rd = '0;

        for (int c = 1; c <= N_CYC; c++) begin
            @(posedge clock); #1;
            cyc = c;
            if (c == 4 || c == mid_rel) rst_n = 1;
            if (!mid_done && c >= 350 && rst_n && rd_q.size() > 0 && rd_q[0].due == c) begin
                rst_n = 0; mid_done = 1; mid_rel = c + 2;
            end
            if (!rst_n) begin
                own = -1; beats = 0; last = 1; rd_q.delete();
            end

            md = mode_of(c);
            for (int i = 0; i < 2; i++) rdy[i] = !mact[i] || macc[i];
            tie_go = (md == M_TIE) && rdy[0] && rdy[1] && tie_rounds < 3;
            if (tie_go) tie_rounds++;
            for (int i = 0; i < 2; i++) if (rdy[i]) new_txn(i, md);

            m0_if.a = ma[0]; m0_if.r = mr[0]; m0_if.w = mw[0]; m0_if.wd = mwd[0]; m0_if.wbe = mwbe[0];
            m1_if.a = ma[1]; m1_if.r = mr[1]; m1_if.w = mw[1]; m1_if.wd = mwd[1]; m1_if.wbe = mwbe[1];

            if (md == M_RAND)       hold = ($urandom_range(0, 4) == 0);
            else if (md == M_STALL) hold = (c >= 80 && c <= 82);
            else                    hold = 0;
            s_if.hold = hold;
            while (slv_q.size() > 0 && slv_q[0].due < c) void'(slv_q.pop_front());
            if (slv_q.size() > 0 && slv_q[0].due == c) begin
                sv = slv_q.pop_front();
                s_if.rd = hsh(sv.a);
            end else s_if.rd = $urandom;

            e = '{in_rst: 1'b0, h0: 1'b0, h1: 1'b0, r: 1'b0, w: 1'b0, a: '0, wd: '0, wbe: '0};
            macc[0] = 0; macc[1] = 0;
            if (!rst_n) begin
                e.in_rst = 1;
                exp_q.push_back(e);
            end else begin
                g = -1;
                if (own >= 0 && mact[own] && !(beats >= MAX_BURST && mact[1-own])) g = own;
                else if (mact[0] && mact[1]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    g = 1 - last;
`else
                    g = 1;
`endif
                end else if (mact[0]) g = 0;
                else if (mact[1]) g = 1;
                acc = (g >= 0) && !hold;
                e.h0 = (g == 0) ? hold : mact[0];
                e.h1 = (g == 1) ? hold : mact[1];
                if (g >= 0) begin
                    e.r = mr[g]; e.w = mw[g]; e.a = ma[g]; e.wd = mwd[g]; e.wbe = mwbe[g];
                end
                exp_q.push_back(e);
                if (acc) begin
                    macc[g] = 1;
                    if (mr[g]) rd_q.push_back('{c + RD_LAT, g, hsh(ma[g])});
                    beats = (own == g) ? ((beats + 1 > MAX_BURST) ? MAX_BURST : beats + 1) : 1;
                    own = g; last = g;
                end else if (own >= 0 && !mact[own]) begin
                    own = -1; beats = 0;
                end
            end
        end
        @(negedge clock); #1;
        chk("rd_drained", 32'(rd_q.size()), 32'h0);
        chk("exp_drained", 32'(exp_q.size()), 32'h0);
        chk("mid_reset_hit", 32'(mid_done), 32'h1);
        done = 1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
